// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, grant IDs and
// the per-request control bundle (address plus size/extension flags).
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned REQ_W  = 35;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_P = 1'b0,
        GNT_D = 1'b1
    } gnt_id_e;

    typedef struct packed {
        logic [0:ADDR_W-1] addr;
        logic              byte_sz;
        logic              half;
        logic              sext;
    } req_ctrl_t;

    function automatic req_ctrl_t pack_ctrl(
        input logic [0:ADDR_W-1] addr,
        input logic              byte_sz,
        input logic              half,
        input logic              sext
    );
        req_ctrl_t c;
        c.addr    = addr;
        c.byte_sz = byte_sz;
        c.half    = half;
        c.sext    = sext;
        return c;
    endfunction

endpackage

// File: rtl/dmem_arb_select.sv
// Winner select between the CPU (P) and DMA (D) requesters, with a streak
// counter that forces D in after PROC_STREAK consecutive contended P grants.
module dmem_arb_select
    import dmem_arb_pkg::*;
#(
    parameter int unsigned PROC_STREAK = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    p_req,
    input  logic    d_req,
    input  logic    arb_en,
    output logic    gnt_valid_c,
    output gnt_id_e gnt_id_c
);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;

    always_comb begin
        gnt_valid_c = arb_en & (p_req | d_req);
        gnt_id_c    = GNT_P;
        if (d_req && (!p_req || (streak_q == CNT_W'(PROC_STREAK)))) begin
            gnt_id_c = GNT_D;
        end
    end

    // Streak only grows while D is actually waiting behind a P grant.
    always_comb begin
        streak_d = streak_q;
        if (!d_req) begin
            streak_d = '0;
        end else if (gnt_valid_c) begin
            if (gnt_id_c == GNT_D) begin
                streak_d = '0;
            end else if (streak_q != '1) begin
                streak_d = streak_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage and a
// DMA/debug requester; one transfer is IDLE -> ACCESS x MEM_LAT -> DONE.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT     = 2,
    parameter int unsigned PROC_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic [0:ADDR_W-1] p_addr,
    input  logic [0:DATA_W-1] p_wdata,
    input  logic              p_we,
    input  logic              p_byte,
    input  logic              p_half,
    input  logic              p_sext,
    output logic              p_ack,
    output logic [0:DATA_W-1] p_rdata,
    input  logic              d_req,
    input  logic [0:ADDR_W-1] d_addr,
    input  logic [0:DATA_W-1] d_wdata,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic              d_half,
    input  logic              d_sext,
    output logic              d_ack,
    output logic [0:DATA_W-1] d_rdata,
    output logic [0:ADDR_W-1] mem_addr,
    output logic [0:DATA_W-1] mem_wdata,
    output logic              mem_we,
    output logic              mem_byte,
    output logic              mem_half,
    output logic              mem_sext,
    input  logic [0:DATA_W-1] mem_rdata,
    output logic              stall_proc
);

    arb_state_e        state_q;
    gnt_id_e           owner_q;
    logic [CNT_W-1:0]  lat_cnt_q;
    logic              p_ack_q;
    logic              d_ack_q;
    logic [0:DATA_W-1] p_rdata_q;
    logic [0:DATA_W-1] d_rdata_q;
    req_ctrl_t         ctrl_q;
    logic [0:DATA_W-1] wdata_q;
    logic              we_q;

    logic              gnt_valid_c;
    gnt_id_e           gnt_id_c;
    req_ctrl_t         sel_ctrl_c;
    logic [0:DATA_W-1] sel_wdata_c;
    logic              sel_we_c;
    logic [0:DATA_W-1] load_data_c;

    dmem_arb_select #(
        .PROC_STREAK (PROC_STREAK)
    ) u_select (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_req       (p_req),
        .d_req       (d_req),
        .arb_en      (state_q == ST_IDLE),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    // Fields of whichever requester wins this IDLE cycle.
    always_comb begin
        sel_ctrl_c  = pack_ctrl(p_addr, p_byte, p_half, p_sext);
        sel_wdata_c = p_wdata;
        sel_we_c    = p_we;
        if (gnt_id_c == GNT_D) begin
            sel_ctrl_c  = pack_ctrl(d_addr, d_byte, d_half, d_sext);
            sel_wdata_c = d_wdata;
            sel_we_c    = d_we;
        end
    end

    // Stores return zero read data.
    always_comb begin
        load_data_c = we_q ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= GNT_P;
            lat_cnt_q <= '0;
            p_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
            ctrl_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid_c) begin
                        owner_q   <= gnt_id_c;
                        ctrl_q    <= sel_ctrl_c;
                        wdata_q   <= sel_wdata_c;
                        we_q      <= sel_we_c;
                        lat_cnt_q <= CNT_W'(MEM_LAT - 1);
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt_q == '0) begin
                        if (owner_q == GNT_P) begin
                            p_ack_q   <= 1'b1;
                            p_rdata_q <= load_data_c;
                        end else begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= load_data_c;
                        end
                        ctrl_q  <= '0;
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    p_ack_q   <= 1'b0;
                    d_ack_q   <= 1'b0;
                    p_rdata_q <= '0;
                    d_rdata_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    p_ack_q   <= 1'b0;
                    d_ack_q   <= 1'b0;
                    p_rdata_q <= '0;
                    d_rdata_q <= '0;
                    ctrl_q    <= '0;
                    wdata_q   <= '0;
                    we_q      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Field registers are zero outside ACCESS, so they drive the pins directly.
    assign mem_addr   = ctrl_q.addr;
    assign mem_byte   = ctrl_q.byte_sz;
    assign mem_half   = ctrl_q.half;
    assign mem_sext   = ctrl_q.sext;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign p_ack      = p_ack_q;
    assign d_ack      = d_ack_q;
    assign p_rdata    = p_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign stall_proc = p_req & ~p_ack_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table for single transfers,
// hand sequences for arbitration, throughput, reset abort and MEM_LAT = 1.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        p_req, p_we, p_byte, p_half, p_sext;
    logic [31:0] p_addr, p_wdata;
    logic        d_req, d_we, d_byte, d_half, d_sext;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] mem_rdata;

    logic        p_ack, d_ack, mem_we, mem_byte, mem_half, mem_sext, stall_proc;
    logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata;

    logic        p_ack1, d_ack1, mem_we1, mem_byte1, mem_half1, mem_sext1, stall_proc1;
    logic [31:0] p_rdata1, d_rdata1, mem_addr1, mem_wdata1;

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.MEM_LAT(2), .PROC_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we),
        .p_byte(p_byte), .p_half(p_half), .p_sext(p_sext),
        .p_ack(p_ack), .p_rdata(p_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_byte(d_byte), .d_half(d_half), .d_sext(d_sext),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_byte(mem_byte), .mem_half(mem_half), .mem_sext(mem_sext),
        .mem_rdata(mem_rdata), .stall_proc(stall_proc)
    );

    dmem_port_arbiter #(.MEM_LAT(1), .PROC_STREAK(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_addr(p_addr), .p_wdata(p_wdata), .p_we(p_we),
        .p_byte(p_byte), .p_half(p_half), .p_sext(p_sext),
        .p_ack(p_ack1), .p_rdata(p_rdata1),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_byte(d_byte), .d_half(d_half), .d_sext(d_sext),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_byte(mem_byte1), .mem_half(mem_half1), .mem_sext(mem_sext1),
        .mem_rdata(mem_rdata), .stall_proc(stall_proc1)
    );

    typedef struct {
        logic        p_req;
        logic [31:0] p_addr;
        logic        p_we;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_we;
        logic        d_byte;
        logic        e_p_ack;
        logic [31:0] e_p_rdata;
        logic        e_d_ack;
        logic [31:0] e_d_rdata;
        logic        e_stall;
        logic [31:0] e_mem_addr;
        logic        e_mem_we;
        logic        e_mem_byte;
        logic [31:0] e_mem_wdata;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p_req = 0; p_we = 0; p_byte = 0; p_half = 0; p_sext = 0;
        p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_byte = 0; d_half = 0; d_sext = 0;
        d_addr = 0; d_wdata = 0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    int          order [10];
    int          exp_order [10];
    int          n_ack;
    int          ack_cyc [3];
    logic [3:0]  exp_ack;

    initial begin
        // P load, idle, D byte store, idle (mem_rdata = DEADBEEF throughout)
        vt[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0,      0, 0, 0};
        vt[1] = '{1, 32'h100, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h100, 0, 0, 0};
        vt[2] = '{1, 32'h100, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h100, 0, 0, 0};
        vt[3] = '{1, 32'h100, 0, 0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
        vt[4] = '{0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[5] = '{0, 0, 0, 1, 32'h40, 32'hA5, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[6] = '{0, 0, 0, 1, 32'h40, 32'hA5, 1, 1,  0, 0, 0, 0, 0, 32'h40, 1, 1, 32'hA5};
        vt[7] = '{0, 0, 0, 1, 32'h40, 32'hA5, 1, 1,  0, 0, 0, 0, 0, 32'h40, 1, 1, 32'hA5};
        vt[8] = '{0, 0, 0, 1, 32'h40, 32'hA5, 1, 1,  0, 0, 1, 0, 0, 0, 0, 0, 0};
        vt[9] = '{0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        idle_inputs();
        mem_rdata = 32'hDEADBEEF;
        rst_n = 0;
        wait_cycles(3);
        @(negedge clk);
        chk("rst_p_ack", 32'(p_ack), 0);
        chk("rst_d_ack", 32'(d_ack), 0);
        chk("rst_p_rdata", p_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_stall", 32'(stall_proc), 0);
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            p_req = vt[i].p_req; p_addr = vt[i].p_addr; p_we = vt[i].p_we;
            d_req = vt[i].d_req; d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata;
            d_we = vt[i].d_we; d_byte = vt[i].d_byte;
            @(negedge clk);
            chk($sformatf("v%0d_p_ack", i), 32'(p_ack), 32'(vt[i].e_p_ack));
            chk($sformatf("v%0d_p_rdata", i), p_rdata, vt[i].e_p_rdata);
            chk($sformatf("v%0d_d_ack", i), 32'(d_ack), 32'(vt[i].e_d_ack));
            chk($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].e_d_rdata);
            chk($sformatf("v%0d_stall", i), 32'(stall_proc), 32'(vt[i].e_stall));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_mem_addr);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_mem_we));
            chk($sformatf("v%0d_mem_byte", i), 32'(mem_byte), 32'(vt[i].e_mem_byte));
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].e_mem_wdata);
        end

        // Continuous contention: D forced in after every four P grants.
        for (int i = 0; i < 10; i++) order[i] = 2;
        @(posedge clk); #1;
        p_req = 1; p_addr = 32'h300; d_req = 1; d_addr = 32'h400; d_we = 0; d_byte = 0;
        n_ack = 0;
        for (int c = 0; c < 80 && n_ack < 10; c++) begin
            @(negedge clk);
            if (p_ack && d_ack) chk("arb_dual_ack", 32'(p_ack & d_ack), 0);
            if (p_ack) begin order[n_ack] = 0; n_ack++; end
            else if (d_ack) begin order[n_ack] = 1; n_ack++; end
        end
        chk("arb_ack_count", 32'(n_ack), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("arb_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        @(posedge clk); #1;
        idle_inputs();
        wait_cycles(6);

        // Back-to-back P requests: acks every MEM_LAT+2 cycles.
        for (int i = 0; i < 3; i++) ack_cyc[i] = -100;
        p_req = 1; p_addr = 32'h104;
        n_ack = 0;
        for (int c = 0; c < 40 && n_ack < 3; c++) begin
            @(negedge clk);
            if (p_ack) begin ack_cyc[n_ack] = c; n_ack++; end
        end
        chk("b2b_count", 32'(n_ack), 3);
        chk("b2b_first", 32'(ack_cyc[0]), 3);
        chk("b2b_gap0", 32'(ack_cyc[1] - ack_cyc[0]), 4);
        chk("b2b_gap1", 32'(ack_cyc[2] - ack_cyc[1]), 4);
        @(posedge clk); #1;
        idle_inputs();
        wait_cycles(6);

        // Reset during ACCESS of a store aborts it without an ack.
        p_req = 1; p_we = 1; p_addr = 32'h500; p_wdata = 32'h1234;
        @(posedge clk); #1;
        chk("rst_mid_we_before", 32'(mem_we), 1);
        rst_n = 0;
        #1;
        chk("rst_mid_we_after", 32'(mem_we), 0);
        chk("rst_mid_addr_after", mem_addr, 0);
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_no_ack%0d", c), 32'(p_ack | d_ack), 0);
        end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        p_req = 1; p_addr = 32'h600; mem_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_ack = 4'b1000;
            chk($sformatf("post_rst_ack%0d", c), 32'(p_ack), 32'(exp_ack[c]));
        end
        chk("post_rst_rdata", p_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("post_rst_rdata_clr", p_rdata, 0);
        wait_cycles(6);

        // MEM_LAT = 1 instance: half-word sign-extended load.
        p_req = 1; p_addr = 32'h700; p_half = 1; p_sext = 1; mem_rdata = 32'h0000FFFE;
        @(negedge clk);
        chk("lat1_c0_half", 32'(mem_half1), 0);
        chk("lat1_c0_ack", 32'(p_ack1), 0);
        @(negedge clk);
        chk("lat1_c1_half", 32'(mem_half1), 1);
        chk("lat1_c1_sext", 32'(mem_sext1), 1);
        chk("lat1_c1_addr", mem_addr1, 32'h700);
        chk("lat1_c1_ack", 32'(p_ack1), 0);
        @(negedge clk);
        chk("lat1_c2_half", 32'(mem_half1), 0);
        chk("lat1_c2_sext", 32'(mem_sext1), 0);
        chk("lat1_c2_ack", 32'(p_ack1), 1);
        chk("lat1_c2_rdata", p_rdata1, 32'h0000FFFE);
        @(posedge clk); #1;
        idle_inputs();
        wait_cycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
